// File: rtl/dmem_responder_if.sv
// Request/response handshake between a pipeline or bus master and dmem_responder.
// Signal suffixes are from the responder's point of view.
interface dmem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [63:0] rsp_rdata_o;
  logic        rsp_error_o;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency 64-bit load/store responder over a little-endian byte array.
// The access commits on the edge entering RESP; the response is held until consumed.
module dmem_responder #(
  parameter int MEM_BYTES = 1024,
  parameter int LATENCY   = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  dmem_responder_if.slave  bus
);
  localparam int          AW       = $clog2(MEM_BYTES);
  localparam logic [63:0] LAST_OK  = 64'(MEM_BYTES - 8);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic [7:0]    mem [MEM_BYTES];
  logic [AW-1:0] idx [8];
  logic [63:0]   rd_word;

  logic        commit;
  logic        c_write;
  logic [63:0] c_addr;
  logic [63:0] c_wdata;
  logic        c_err;
  logic        mem_we;

  // With LATENCY=1 the commit edge is the accept edge, so use the live request there.
  assign c_write = (state_q == IDLE) ? bus.req_write_i : write_q;
  assign c_addr  = (state_q == IDLE) ? bus.req_addr_i  : addr_q;
  assign c_wdata = (state_q == IDLE) ? bus.req_wdata_i : wdata_q;
  assign c_err   = (c_addr > LAST_OK);

  assign commit = ((state_q == IDLE) && bus.req_valid_i && (LATENCY == 1)) ||
                  ((state_q == WAIT) && (cnt_q == 4'd1));
  assign mem_we = commit && c_write && !c_err && rst_n_i;

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign idx[gi]             = c_addr[AW-1:0] + AW'(gi);
    assign rd_word[8*gi +: 8]  = mem[idx[gi]];
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int k = 0; k < 8; k++) begin
        mem[idx[k]] <= c_wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    write_d         = write_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    error_d         = error_q;
    bus.req_ready_o = 1'b0;
    bus.rsp_valid_o = 1'b0;

    case (state_q)
      IDLE: begin
        bus.req_ready_o = 1'b1;
        if (bus.req_valid_i) begin
          write_d = bus.req_write_i;
          addr_d  = bus.req_addr_i;
          wdata_d = bus.req_wdata_i;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid_o = 1'b1;
        if (bus.rsp_ready_i) begin
          state_d = IDLE;
          rdata_d = 64'd0;
          error_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Stores and out-of-range accesses report zero data.
    if (commit) begin
      error_d = c_err;
      rdata_d = (c_write || c_err) ? 64'd0 : rd_word;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_error_o = error_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table through a scoreboard on a LATENCY=2 instance,
// plus latency/throughput checks on LATENCY=1 and LATENCY=5 instances and reset corner cases.
module tb_dmem_responder;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  dmem_responder_if bus();
  dmem_responder_if if1();
  dmem_responder_if if5();

  dmem_responder #(.MEM_BYTES(1024), .LATENCY(2)) dut  (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));
  dmem_responder #(.MEM_BYTES(1024), .LATENCY(1)) dut1 (.clk_i(clk), .rst_n_i(rst_n), .bus(if1));
  dmem_responder #(.MEM_BYTES(1024), .LATENCY(5)) dut5 (.clk_i(clk), .rst_n_i(rst_n), .bus(if5));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 5);
  endfunction

  function automatic logic get_ready(input int k);
    return (k == 0) ? bus.req_ready_o : ((k == 1) ? if1.req_ready_o : if5.req_ready_o);
  endfunction

  function automatic logic get_valid(input int k);
    return (k == 0) ? bus.rsp_valid_o : ((k == 1) ? if1.rsp_valid_o : if5.rsp_valid_o);
  endfunction

  function automatic logic [63:0] get_rdata(input int k);
    return (k == 0) ? bus.rsp_rdata_o : ((k == 1) ? if1.rsp_rdata_o : if5.rsp_rdata_o);
  endfunction

  function automatic logic get_err(input int k);
    return (k == 0) ? bus.rsp_error_o : ((k == 1) ? if1.rsp_error_o : if5.rsp_error_o);
  endfunction

  task automatic set_req(input int k, input logic v, input logic wr,
                         input logic [63:0] a, input logic [63:0] d);
    case (k)
      0: begin bus.req_valid_i = v; bus.req_write_i = wr; bus.req_addr_i = a; bus.req_wdata_i = d; end
      1: begin if1.req_valid_i = v; if1.req_write_i = wr; if1.req_addr_i = a; if1.req_wdata_i = d; end
      default: begin if5.req_valid_i = v; if5.req_write_i = wr; if5.req_addr_i = a; if5.req_wdata_i = d; end
    endcase
  endtask

  task automatic set_rr(input int k, input logic v);
    case (k)
      0:       bus.rsp_ready_i = v;
      1:       if1.rsp_ready_i = v;
      default: if5.rsp_ready_i = v;
    endcase
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // One request through to a consumed response; expected values go through the scoreboard.
  task automatic issue(input int k, input logic wr, input logic [63:0] a, input logic [63:0] d,
                       input logic [63:0] exp_rd, input logic exp_err, input string tag);
    int   lat;
    exp_t e;
    @(negedge clk);
    chk({tag, " req_ready"}, 64'(get_ready(k)), 64'd1);
    set_rr(k, 1'b0);
    set_req(k, 1'b1, wr, a, d);
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.lat   = lat_of(k);
    sb_q.push_back(e);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      // Scramble the request after acceptance; the responder must have latched it.
      set_req(k, 1'b0, ~wr, ~a, ~d);
    end while (!get_valid(k) && lat < 40);
    e = sb_q.pop_front();
    chk({tag, " latency"}, 64'(lat), 64'(e.lat));
    chk({tag, " rdata"}, get_rdata(k), e.rdata);
    chk({tag, " error"}, 64'(get_err(k)), 64'(e.err));
    $display("txn dut%0d %s wr=%0b addr=0x%0h rdata=0x%0h err=%0b lat=%0d",
             k, tag, wr, a, get_rdata(k), get_err(k), lat);
    @(negedge clk);
    set_rr(k, 1'b1);
    @(posedge clk);
    #1;
    set_rr(k, 1'b0);
    chk({tag, " rsp_clear"}, 64'(get_valid(k)), 64'd0);
  endtask

  // With rsp_ready held high, requests are taken every LATENCY+1 cycles.
  task automatic tput(input int k);
    int acc[$];
    int n;
    n = 3 * (lat_of(k) + 1) + 1;
    @(negedge clk);
    set_rr(k, 1'b1);
    set_req(k, 1'b1, 1'b0, 64'h40, 64'd0);
    for (int c = 0; c < n; c++) begin
      if (get_ready(k)) acc.push_back(c);
      @(negedge clk);
    end
    set_req(k, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (lat_of(k) + 2) @(negedge clk);
    set_rr(k, 1'b0);
    $display("txn dut%0d throughput accepts=%0d over %0d cycles", k, acc.size(), n);
    chk("tput count", 64'(acc.size()), 64'd4);
    for (int i = 1; i < acc.size(); i++) begin
      chk("tput spacing", 64'(acc[i] - acc[i-1]), 64'(lat_of(k) + 1));
    end
    chk("tput drained", 64'(get_valid(k)), 64'd0);
  endtask

  vec_t vecs[15];

  initial begin
    int   lat;
    logic [63:0] snap;

    vecs[0]  = '{1'b1, 64'h18,                 64'h0102030405060708, 64'd0,                 1'b0};
    vecs[1]  = '{1'b1, 64'h10,                 64'h1122334455667788, 64'd0,                 1'b0};
    vecs[2]  = '{1'b0, 64'h10,                 64'd0,                64'h1122334455667788, 1'b0};
    vecs[3]  = '{1'b0, 64'h11,                 64'd0,                64'h0811223344556677, 1'b0};
    vecs[4]  = '{1'b1, 64'd1016,               64'hCAFEBABEDEADBEEF, 64'd0,                 1'b0};
    vecs[5]  = '{1'b0, 64'd1016,               64'd0,                64'hCAFEBABEDEADBEEF, 1'b0};
    vecs[6]  = '{1'b0, 64'd1017,               64'd0,                64'd0,                 1'b1};
    vecs[7]  = '{1'b1, 64'd1020,               64'hFFFFFFFFFFFFFFFF, 64'd0,                 1'b1};
    vecs[8]  = '{1'b0, 64'd1016,               64'd0,                64'hCAFEBABEDEADBEEF, 1'b0};
    vecs[9]  = '{1'b0, 64'hFFFFFFFFFFFFFFFC,   64'd0,                64'd0,                 1'b1};
    vecs[10] = '{1'b0, 64'h0000000100000010,   64'd0,                64'd0,                 1'b1};
    vecs[11] = '{1'b0, 64'd1024,               64'd0,                64'd0,                 1'b1};
    vecs[12] = '{1'b1, 64'h33,                 64'h8877665544332211, 64'd0,                 1'b0};
    vecs[13] = '{1'b0, 64'h33,                 64'd0,                64'h8877665544332211, 1'b0};
    vecs[14] = '{1'b1, 64'h20,                 64'h5555666677778888, 64'd0,                 1'b0};

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_req(k, 1'b0, 1'b0, 64'd0, 64'd0);
      set_rr(k, 1'b0);
    end
    #12;
    chk("reset req_ready", 64'(bus.req_ready_o), 64'd1);
    chk("reset rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("reset rdata", bus.rsp_rdata_o, 64'd0);
    chk("reset error", 64'(bus.rsp_error_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      issue(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err,
            $sformatf("vec%0d", i));
    end

    // Backpressure: response held stable, new requests refused in RESP.
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 64'h10, 64'd0);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      set_req(0, 1'b1, 1'b1, 64'h10, 64'd0);
    end while (!bus.rsp_valid_o && lat < 40);
    chk("bp latency", 64'(lat), 64'd2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
      chk("bp rdata", bus.rsp_rdata_o, 64'h1122334455667788);
      chk("bp error", 64'(bus.rsp_error_o), 64'd0);
      chk("bp req_ready", 64'(bus.req_ready_o), 64'd0);
    end
    $display("txn dut0 backpressure load addr=0x10 held 5 cycles");
    set_rr(0, 1'b1);
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 1'b0, 64'd0, 64'd0);
    set_rr(0, 1'b0);
    chk("bp release rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("bp release req_ready", 64'(bus.req_ready_o), 64'd1);
    repeat (3) begin
      @(negedge clk);
      chk("bp no accept", 64'(bus.rsp_valid_o), 64'd0);
    end
    issue(0, 1'b0, 64'h10, 64'd0, 64'h1122334455667788, 1'b0, "bp reload");

    // Latency sweep and throughput across instances.
    issue(1, 1'b1, 64'h40, 64'hA1A2A3A4A5A6A7A8, 64'd0, 1'b0, "l1 store");
    issue(1, 1'b0, 64'h40, 64'd0, 64'hA1A2A3A4A5A6A7A8, 1'b0, "l1 load");
    issue(1, 1'b0, 64'd1017, 64'd0, 64'd0, 1'b1, "l1 oob");
    issue(2, 1'b1, 64'h40, 64'h0F1E2D3C4B5A6978, 64'd0, 1'b0, "l5 store");
    issue(2, 1'b0, 64'h40, 64'd0, 64'h0F1E2D3C4B5A6978, 1'b0, "l5 load");
    issue(2, 1'b0, 64'd1017, 64'd0, 64'd0, 1'b1, "l5 oob");
    tput(0);
    tput(1);
    tput(2);

    // Reset during WAIT discards the pending store.
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 64'h20, 64'hDEADBEEFCAFEF00D);
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 1'b0, 64'd0, 64'd0);
    chk("midrst in wait", 64'(bus.req_ready_o), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("midrst req_ready", 64'(bus.req_ready_o), 64'd1);
    chk("midrst rdata", bus.rsp_rdata_o, 64'd0);
    chk("midrst error", 64'(bus.rsp_error_o), 64'd0);
    $display("txn dut0 reset during wait store addr=0x20");
    // Requests presented in reset are ignored.
    set_req(0, 1'b1, 1'b1, 64'h20, 64'hDEADBEEFCAFEF00D);
    repeat (3) begin
      @(negedge clk);
      chk("rst idle rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    end
    set_req(0, 1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post rst no rsp", 64'(bus.rsp_valid_o), 64'd0);
    end
    issue(0, 1'b0, 64'h20, 64'd0, 64'h5555666677778888, 1'b0, "post rst load");

    // Reset during RESP drops the response immediately.
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 64'h10, 64'd0);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      set_req(0, 1'b0, 1'b0, 64'd0, 64'd0);
    end while (!bus.rsp_valid_o && lat < 40);
    snap = bus.rsp_rdata_o;
    chk("resp rst pre rdata", snap, 64'h1122334455667788);
    #2;
    rst_n = 1'b0;
    #1;
    chk("resp rst rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("resp rst rdata", bus.rsp_rdata_o, 64'd0);
    $display("txn dut0 reset during resp load addr=0x10");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("resp rst idle", 64'(bus.rsp_valid_o), 64'd0);
    end
    issue(0, 1'b0, 64'h10, 64'd0, 64'h1122334455667788, 1'b0, "mem kept");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
